// File: rtl/flag_unit_if.sv
// Bundle of EX-stage flag signals between the pipeline and flag_unit.
// The pipeline drives through master; flag_unit uses slave.
interface flag_unit_if #(
    parameter int FLAG_W = 4,
    parameter int CNT_W  = 16
) ();
    logic [FLAG_W-1:0] banderas;
    logic              flag_we;
    logic [3:0]        cond;
    logic              stall;
    logic              flush;
    logic              exc_enter;
    logic              exc_return;
    logic              cond_ok;
    logic [FLAG_W-1:0] flags_q;
    logic              saved_q;
    logic              seq_err;
    logic [CNT_W-1:0]  wcnt;

    modport master (
        output banderas, flag_we, cond, stall, flush, exc_enter, exc_return,
        input  cond_ok, flags_q, saved_q, seq_err, wcnt
    );

    modport slave (
        input  banderas, flag_we, cond, stall, flush, exc_enter, exc_return,
        output cond_ok, flags_q, saved_q, seq_err, wcnt
    );
endinterface

// File: rtl/flag_unit.sv
// NZCV status register, condition evaluator and one-level exception shadow.
// Optional committed-write counter enabled by defining FLAG_WCNT_EN.
module flag_unit #(
    parameter int FLAG_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    flag_unit_if.slave bus
);

    if (FLAG_W != 4) begin : g_flag_w_check
        $error("flag_unit: FLAG_W must be 4 (NZCV)");
    end

    typedef enum logic {
        NORMAL = 1'b0,
        SAVED  = 1'b1
    } state_t;

    function automatic logic cond_pass(input logic [3:0] c, input logic [FLAG_W-1:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf && !z;
            4'h9:    cond_pass = !cf || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [FLAG_W-1:0] shadow_q, shadow_d;
    logic              saved_q, saved_d;
    logic              seq_err_q, seq_err_d;

    logic              cond_ok;
    logic              commit;
    logic [FLAG_W-1:0] next_flags;
    logic              enter_ok, ret_ok, illegal;

    always_comb begin
        cond_ok    = cond_pass(bus.cond, flags_q);
        commit     = bus.flag_we && cond_ok && !bus.stall && !bus.flush;
        next_flags = commit ? bus.banderas : flags_q;

        enter_ok = bus.exc_enter  && (state_q == NORMAL);
        ret_ok   = bus.exc_return && (state_q == SAVED);
        illegal  = (bus.exc_enter && (state_q == SAVED)) ||
                   (bus.exc_return && (state_q == NORMAL));

        state_d  = state_q;
        shadow_d = shadow_q;
        flags_d  = next_flags;
        if (enter_ok) begin
            state_d  = SAVED;
            // Shadow captures what flags_q will hold after this edge.
            shadow_d = next_flags;
        end else if (ret_ok) begin
            state_d = NORMAL;
            flags_d = shadow_q;
        end

        saved_d   = (state_d == SAVED);
        seq_err_d = seq_err_q || illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= NORMAL;
            flags_q   <= '0;
            shadow_q  <= '0;
            saved_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            shadow_q  <= shadow_d;
            saved_q   <= saved_d;
            seq_err_q <= seq_err_d;
        end
    end

`ifdef FLAG_WCNT_EN
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (commit && (wcnt_q != {CNT_W{1'b1}})) begin
            wcnt_d = wcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign bus.wcnt = wcnt_q;
`else
    assign bus.wcnt = {CNT_W{1'b0}};
`endif

    assign bus.cond_ok = cond_ok;
    assign bus.flags_q = flags_q;
    assign bus.saved_q = saved_q;
    assign bus.seq_err = seq_err_q;

endmodule
